// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types and constants for the pipeline controller.
// Revision : 1.0
// ============================================================================

package pipe_ctrl_pkg;

  localparam int REG_ADDR_W      = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_MEM_TIMEOUT = 255;
  localparam int WAIT_CNT_W      = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ABORT    = 2'd2
  } ctrl_state_e;

  function automatic logic reg_match(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] dest,
    input logic                  dest_en
  );
    return dest_en & (src == dest);
  endfunction

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/pipe_ctrl_unit_hazard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect_unit
// Brief    : Combinational RAW compare between ID sources and in-flight
//            destinations. Build option: PIPE_CTRL_FWD_EN (load-use only).
// Revision : 1.0
// ============================================================================

module hazard_detect_unit
  import pipe_ctrl_pkg::*;
(
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  output logic                  raw
);

  logic w_match1;
  logic w_match2;

`ifdef PIPE_CTRL_FWD_EN
  // Forwarding covers ALU results; only a load in EXE cannot be bypassed.
  logic w_exe_load;
  logic w_unused_mem;

  assign w_exe_load   = exe_mem_r_en & exe_wb_en;
  assign w_match1     = reg_match(id_src1, exe_dest, w_exe_load);
  assign w_match2     = reg_match(id_src2, exe_dest, w_exe_load);
  assign w_unused_mem = ^{mem_dest, mem_wb_en};
`else
  logic w_unused_load;

  assign w_match1      = reg_match(id_src1, exe_dest, exe_wb_en)
                       | reg_match(id_src1, mem_dest, mem_wb_en);
  assign w_match2      = reg_match(id_src2, exe_dest, exe_wb_en)
                       | reg_match(id_src2, mem_dest, mem_wb_en);
  assign w_unused_load = exe_mem_r_en;
`endif

  assign raw = id_valid & (w_match1 | (id_two_src & w_match2));

endmodule : hazard_detect_unit

`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : Pipeline freeze/flush/bubble controller with data-memory wait
//            sequencing, timeout abort and saturating performance counters.
//            Build option: PIPE_CTRL_FWD_EN (forwarding-aware hazard compare).
// Revision : 1.0
// ============================================================================

module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  if_freeze,
  output logic                  id_bubble,
  output logic                  flush,
  output logic                  mem_freeze,
  output logic                  mem_abort,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [WAIT_CNT_W-1:0] C_TIMEOUT  = WAIT_CNT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_CNT_W-1:0] C_WAIT_ONE = WAIT_CNT_W'(1);

  ctrl_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]      flush_count_q, flush_count_d;

  logic w_raw;
  logic w_mem_freeze;
  logic w_flush;
  logic w_if_freeze;
  logic w_id_bubble;
  logic w_abort;

  hazard_detect_unit u_hazard (
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .raw          (w_raw)
  );

  // Priority: memory freeze, then branch flush, then RAW stall.
  assign w_mem_freeze = ((state_q == RUN) || (state_q == MEM_WAIT)) & mem_req & ~mem_ready;
  assign w_abort      = (state_q == ABORT);
  assign w_flush      = branch_taken & ~w_mem_freeze & ~w_abort;
  assign w_if_freeze  = w_mem_freeze | (w_raw & ~branch_taken);
  assign w_id_bubble  = w_raw & ~branch_taken & ~w_mem_freeze;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = C_WAIT_ONE;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == C_TIMEOUT) begin
          state_d       = ABORT;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + C_WAIT_ONE;
        end
      end
      ABORT:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (w_if_freeze && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (w_flush && !(&flush_count_q)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      timeout_err_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      timeout_err_q  <= timeout_err_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // Controls are forced low for the whole reset window, not just after an edge.
  assign mem_freeze   = ~rst & w_mem_freeze;
  assign flush        = ~rst & w_flush;
  assign if_freeze    = ~rst & w_if_freeze;
  assign id_bubble    = ~rst & w_id_bubble;
  assign mem_abort    = ~rst & w_abort;
  assign timeout_err  = timeout_err_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule : pipe_ctrl_unit

`default_nettype wire

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Central pipeline controller for the 5-stage ARM core (IF/ID/EXE/MEM/WB).
- Replaces the tied-off freeze/flush/branch signals with generated controls:
  - RAW-hazard stalls with bubble insertion.
  - Branch flush.
  - Multi-cycle data-memory wait sequencing with timeout.
- Also keeps saturating stall/flush performance counters.
- Sits beside the pipeline; drives the freeze/flush inputs of the IF, IF/ID, ID/EX, EXE/MEM and MEM/WB stage registers.

Parameters:
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before abort (1..65535)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_src1  in  4  ID source register Rn
id_src2  in  4  ID source register Rm/Rd (store)
id_two_src  in  1  id_src2 is actually read
exe_dest  in  4  destination in EXE
exe_wb_en  in  1  EXE instruction writes back
exe_mem_r_en  in  1  EXE instruction is a load
mem_dest  in  4  destination in MEM
mem_wb_en  in  1  MEM instruction writes back
branch_taken  in  1  branch resolved taken in EXE
mem_req  in  1  MEM stage issues read/write
mem_ready  in  1  data memory completes access this cycle
if_freeze  out  1  hold PC and IF/ID register
id_bubble  out  1  load NOP controls into ID/EX
flush  out  1  clear IF/ID and ID/EX
mem_freeze  out  1  hold all stage registers
mem_abort  out  1  one-cycle abort pulse on timeout
timeout_err  out  1  sticky timeout flag
stall_cycles  out  CNT_W  saturating stall-cycle count
flush_count  out  CNT_W  saturating flush-event count

Behaviour:
- Reset (async, active-high): state=RUN; wait_cnt=0; timeout_err=0; stall_cycles=0; flush_count=0.
- All control outputs deassert while rst is high.
- Hazard compare (combinational):
  - raw = id_valid & (match(id_src1) | (id_two_src & match(id_src2))).
  - match(r) = (exe_wb_en & r==exe_dest) | (mem_wb_en & r==mem_dest).
- Combinational outputs, same-cycle. Priority: mem_freeze > flush > hazard.
  - mem_freeze = (state==RUN | state==MEM_WAIT) & mem_req & ~mem_ready.
  - flush = branch_taken & ~mem_freeze.
  - if_freeze = mem_freeze | (raw & ~branch_taken).
  - id_bubble = raw & ~branch_taken & ~mem_freeze.
- Branch dominates hazard: the dependent instruction is squashed, not stalled.
- FSM states: RUN, MEM_WAIT, ABORT.
  - RUN -> MEM_WAIT when mem_req & ~mem_ready; wait_cnt loads 1.
  - MEM_WAIT, mem_ready=1 -> RUN.
  - MEM_WAIT, mem_ready=0 and wait_cnt==MEM_TIMEOUT -> ABORT; timeout_err<=1.
  - MEM_WAIT otherwise: wait_cnt++.
  - ABORT: mem_abort=1, mem_freeze=0, flush=0; next state RUN unconditionally.
  - The MEM instruction is discarded by the pipeline on mem_abort.
- mem_ready in RUN with mem_req: zero-wait access, no freeze, state stays RUN.
- mem_ready high while mem_req low: ignored.
- Counters, both saturating at all-ones (no wrap):
  - stall_cycles += 1 each cycle if_freeze|mem_freeze is high.
  - flush_count += 1 each cycle flush is high.
- branch_taken held high during MEM_WAIT (EXE frozen): no flush while frozen; single flush in the release cycle.
- Reset mid-MEM_WAIT: returns to RUN immediately; no abort pulse.
- timeout_err clears only by reset.

Optional Feature:
- Macro: PIPE_CTRL_FWD_EN.
- Defined (forwarding unit present):
  - match(r) = exe_mem_r_en & exe_wb_en & r==exe_dest.
  - Only load-use hazards stall; the MEM-stage compare is removed.
- Undefined: full EXE+MEM compare as above.
- FSM and counters are identical in both builds.

Decomposition:
- pipe_ctrl_pkg holds:
  - State enum (RUN=2'd0, MEM_WAIT=2'd1, ABORT=2'd2).
  - REG_ADDR_W=4.
  - Default CNT_W and MEM_TIMEOUT constants.
- Sub-module hazard_detect_unit: purely combinational raw compare.
  - Contains the PIPE_CTRL_FWD_EN ifdef.
  - Instantiated once.

Test Plan:
- Hazard stall: id_src1=3, exe_dest=3, exe_wb_en=1, id_valid=1 -> if_freeze=1, id_bubble=1, flush=0 for 1 cycle; stall_cycles=1. With FWD_EN and exe_mem_r_en=0 -> no stall.
- Branch over hazard: same as above plus branch_taken=1 -> flush=1, if_freeze=0, id_bubble=0; flush_count=1.
- Memory wait: mem_req=1, mem_ready low 3 cycles then high -> mem_freeze=1 exactly 3 cycles; state RUN->MEM_WAIT->RUN; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> abort pulse one cycle after wait_cnt hits 4. Checks: mem_abort=1 and mem_freeze=0 in that cycle; timeout_err stays 1; state returns to RUN.
- Branch during wait: branch_taken=1 for the whole 2-cycle wait -> flush=0 while frozen, flush=1 in the release cycle; flush_count increments once.
- Async reset mid-MEM_WAIT: assert rst between clock edges -> outputs 0 immediately; counters 0; state RUN after deassert with no mem_abort. CNT_W=4 saturation: 20 stall cycles -> stall_cycles=15.
